// File: rtl/lcd_text_driver_if.sv
// lcd_text_driver_if: text-buffer lookup and HD44780 write-bus signals of the LCD text driver
interface lcd_text_driver_if;
  logic [4:0] char_index;
  logic [7:0] char_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;
  modport master (output char_index, lcd_rs, lcd_rw, lcd_e, lcd_data, input char_data);
  modport slave  (input char_index, lcd_rs, lcd_rw, lcd_e, lcd_data, output char_data);
endinterface

// File: rtl/lcd_text_driver.sv
// lcd_text_driver: power-up, init and continuous 16x2 screen refresh of an HD44780 LCD from a 32-byte text buffer
module lcd_text_driver #(
  parameter int POWERUP_CYC  = 750000,
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               refresh_en,
  output logic               busy,
  output logic               frame_done,
  lcd_text_driver_if.master  bus
);
  localparam int MAX_A = POWERUP_CYC > E_PULSE_CYC ? POWERUP_CYC : E_PULSE_CYC;
  localparam int MAX_B = CMD_WAIT_CYC > CLR_WAIT_CYC ? CMD_WAIT_CYC : CLR_WAIT_CYC;
  localparam int CW = $clog2(MAX_A > MAX_B ? MAX_A : MAX_B);
  typedef enum logic [2:0] {PWRUP, INIT, ADDR1, LINE1, ADDR2, LINE2, DONE, IDLE} state_t;
  typedef enum logic [1:0] {FETCH, SETUP, PULSE, HOLD} sub_t;
  state_t        state, state_n;
  sub_t          sub, sub_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    ini, ini_n;
  logic [4:0]    idx_n;
  logic [7:0]    data_n, init_nxt;
  logic          rs_n, hold_end;
  assign bus.lcd_rw = 1'b0;
  // next init command and end of the hold time (clear display needs the long wait)
  always_comb begin
    init_nxt = ini == 2'd0 ? 8'h0C : ini == 2'd1 ? 8'h01 : 8'h06;
    hold_end = cnt == ((!bus.lcd_rs && bus.lcd_data == 8'h01) ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1));
  end
  // sequencer: frame phase plus fetch/setup/pulse/hold sub-phase of each bus write
  always_comb begin
    state_n = state;
    sub_n   = sub;
    cnt_n   = cnt + 1'b1;
    ini_n   = ini;
    idx_n   = bus.char_index;
    rs_n    = bus.lcd_rs;
    data_n  = bus.lcd_data;
    case (state)
      PWRUP: if (cnt == CW'(POWERUP_CYC - 1)) begin
        state_n = INIT;
        sub_n   = SETUP;
        cnt_n   = '0;
        ini_n   = 2'd0;
        rs_n    = 1'b0;
        data_n  = 8'h38;
      end
      DONE, IDLE: if (refresh_en) begin
        state_n = ADDR1;
        sub_n   = SETUP;
        cnt_n   = '0;
        rs_n    = 1'b0;
        data_n  = 8'h80;
      end else state_n = IDLE;
      default: case (sub)
        FETCH: begin
          sub_n  = SETUP;
          cnt_n  = '0;
          rs_n   = 1'b1;
          data_n = bus.char_data;
        end
        SETUP: begin
          sub_n = PULSE;
          cnt_n = '0;
        end
        PULSE: if (cnt == CW'(E_PULSE_CYC - 1)) begin
          sub_n = HOLD;
          cnt_n = '0;
        end
        default: if (hold_end) begin
          cnt_n = '0;
          sub_n = SETUP;
          case (state)
            INIT: if (ini != 2'd3) begin
              ini_n  = ini + 2'd1;
              rs_n   = 1'b0;
              data_n = init_nxt;
            end else begin
              state_n = ADDR1;
              rs_n    = 1'b0;
              data_n  = 8'h80;
            end
            ADDR1: begin
              state_n = LINE1;
              sub_n   = FETCH;
              idx_n   = 5'd0;
            end
            LINE1: if (bus.char_index != 5'd15) begin
              sub_n = FETCH;
              idx_n = bus.char_index + 5'd1;
            end else begin
              state_n = ADDR2;
              rs_n    = 1'b0;
              data_n  = 8'hC0;
            end
            ADDR2: begin
              state_n = LINE2;
              sub_n   = FETCH;
              idx_n   = 5'd16;
            end
            default: if (bus.char_index != 5'd31) begin
              sub_n = FETCH;
              idx_n = bus.char_index + 5'd1;
            end else state_n = DONE;
          endcase
        end
      endcase
    endcase
  end
  // state and registered outputs; outputs follow the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= PWRUP;
      sub            <= SETUP;
      cnt            <= '0;
      ini            <= '0;
      bus.char_index <= '0;
      bus.lcd_rs     <= 1'b0;
      bus.lcd_e      <= 1'b0;
      bus.lcd_data   <= '0;
      busy           <= 1'b1;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_n;
      sub            <= sub_n;
      cnt            <= cnt_n;
      ini            <= ini_n;
      bus.char_index <= idx_n;
      bus.lcd_rs     <= rs_n;
      bus.lcd_e      <= sub_n == PULSE;
      bus.lcd_data   <= data_n;
      busy           <= state_n != IDLE;
      frame_done     <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_lcd_text_driver.sv
// tb_lcd_text_driver: randomized scoreboard bench for the LCD text driver
module tb_lcd_text_driver;
  localparam int PU = 10, EP = 2, CM = 4, CL = 8;
  logic clk = 0, rst = 0, refresh_en = 0;
  logic busy, frame_done;
  lcd_text_driver_if bus ();
  lcd_text_driver #(.POWERUP_CYC(PU), .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CM), .CLR_WAIT_CYC(CL)) dut (
    .clk(clk), .rst(rst), .refresh_en(refresh_en), .busy(busy), .frame_done(frame_done), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {bit done; bit rs; logic [7:0] d; int gap; int hold;} ev_t;
  ev_t q[$];
  ev_t me;
  logic [7:0] mem [32];
  int n_chk = 0, n_pass = 0, done_cnt = 0, cyc = 0, last_ref = 0, win = 0, k = 0, bad = 0;
  int last_hold = 0, force_gap = 0;
  bit use_force = 0;
  logic prev_e = 0, cap_rs = 0;
  logic [7:0] cap_d = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // expected gap: rise-to-rise is pulse + previous hold + setup, plus one fetch cycle for characters
  task automatic push(input bit done, input bit rs, input logic [7:0] d);
    ev_t e;
    e.done = done;
    e.rs = rs;
    e.d = d;
    e.gap = use_force ? force_gap : done ? EP + last_hold : EP + last_hold + 1 + int'(rs);
    e.hold = (!rs && d == 8'h01) ? CL : CM;
    use_force = 0;
    last_hold = e.hold;
    q.push_back(e);
  endtask

  task automatic push_init();
    use_force = 1;
    force_gap = PU + 2;
    push(0, 0, 8'h38);
    push(0, 0, 8'h0C);
    push(0, 0, 8'h01);
    push(0, 0, 8'h06);
  endtask

  task automatic push_frame();
    push(0, 0, 8'h80);
    for (int i = 0; i < 16; i++) push(0, 1, mem[i]);
    push(0, 0, 8'hC0);
    for (int i = 16; i < 32; i++) push(0, 1, mem[i]);
    push(1, 0, 8'h00);
  endtask

  task automatic wait_done(input int n, input int budget);
    int i = 0;
    while (done_cnt < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk("frame_done_count", done_cnt, n);
  endtask

  task automatic chk_reset_vals();
    chk("rst_char_index", bus.char_index, 0);
    chk("rst_lcd_rs", bus.lcd_rs, 0);
    chk("rst_lcd_rw", bus.lcd_rw, 0);
    chk("rst_lcd_e", bus.lcd_e, 0);
    chk("rst_lcd_data", bus.lcd_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_frame_done", frame_done, 0);
  endtask

  // monitor: pops the scoreboard on every write strobe and frame_done, and drives the text buffer
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      last_ref = cyc;
      win = 0;
      prev_e = 0;
    end else begin
      if (win > 0) begin
        k++;
        if (bus.lcd_e !== (k < EP) || bus.lcd_rs !== cap_rs || bus.lcd_data !== cap_d) bad++;
        win--;
        if (win == 0) chk("write_stability", bad, 0);
      end
      if (bus.lcd_e && !prev_e) begin
        chk("write_pending", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          me = q.pop_front();
          chk("event_is_write", me.done, 0);
          chk("lcd_rs", bus.lcd_rs, me.rs);
          chk("lcd_data", bus.lcd_data, me.d);
          chk("lcd_rw", bus.lcd_rw, 0);
          if (me.gap >= 0) chk("rise_gap", cyc - last_ref, me.gap);
          last_ref = cyc;
          cap_rs = bus.lcd_rs;
          cap_d = bus.lcd_data;
          k = 0;
          bad = 0;
          win = EP + me.hold - 1;
        end
      end
      if (frame_done) begin
        chk("done_pending", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          me = q.pop_front();
          chk("event_is_done", me.done, 1);
          chk("done_gap", cyc - last_ref, me.gap);
          last_ref = cyc;
        end
        done_cnt++;
      end
      prev_e = bus.lcd_e;
    end
    bus.char_data = (win > 0) ? 8'($urandom) : mem[bus.char_index];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'h41 + 8'(i);
      mem[16 + i] = i < 10 ? 8'h30 + 8'(i) : 8'h61 + 8'(i - 10);
    end
    refresh_en = 1;
    rst = 0;
    repeat (5) @(posedge clk);
    #1 chk_reset_vals();
    push_init();
    push_frame();
    use_force = 1;
    force_gap = 2;
    push_frame();
    use_force = 1;
    force_gap = 2;
    push_frame();
    rst = 1;
    wait_done(2, 2000);
    repeat (60) @(posedge clk);
    #1 refresh_en = 0;
    wait_done(3, 1000);
    repeat (5) @(posedge clk);
    #1 chk("idle_busy", busy, 0);
    chk("idle_lcd_e", bus.lcd_e, 0);
    chk("queue_drained", q.size(), 0);
    repeat (20) @(posedge clk);
    #1 for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    use_force = 1;
    force_gap = -1;
    push_frame();
    refresh_en = 1;
    repeat (3) @(posedge clk);
    #1 refresh_en = 0;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (bus.lcd_e && bus.lcd_rs && bus.char_index == 5'd20) found = 1;
    end
    chk("char20_pulse_seen", found, 1);
    #2 rst = 0;
    q.delete();
    #1 chk_reset_vals();
    repeat (3) @(posedge clk);
    #1 for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    push_init();
    push_frame();
    rst = 1;
    wait_done(4, 2000);
    repeat (5) @(posedge clk);
    #1 chk("final_idle_busy", busy, 0);
    chk("final_queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
